// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: FSM states, RISC-V width
// codes, load extension codes and the request legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    EXT_ZB = 3'b000,
    EXT_ZH = 3'b001,
    EXT_SB = 3'b010,
    EXT_SH = 3'b011,
    EXT_W  = 3'b100
  } ext_e;

  // True when the width code exists for the direction and the address is
  // naturally aligned for that width.
  function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:  ok = 1'b1;
      F3_H:  ok = (lo[0] == 1'b0);
      F3_W:  ok = (lo == 2'b00);
      F3_BU: ok = !we;
      F3_HU: ok = !we && (lo[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Maps a load width code to the extension applied to the shifted word.
  function automatic ext_e ext_code(input logic [2:0] f3);
    ext_e e;
    e = EXT_W;
    case (f3)
      F3_B:  e = EXT_SB;
      F3_H:  e = EXT_SH;
      F3_W:  e = EXT_W;
      F3_BU: e = EXT_ZB;
      F3_HU: e = EXT_ZH;
      default: e = EXT_W;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Sign/zero extension of a load word already shifted so the addressed
// byte or halfword sits in the low lanes.
module load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] shifted_i,
  input  ext_e        ext_i,
  output logic [31:0] result_o
);

  // Select the extension for the requested width.
  always_comb begin
    result_o = 32'h0;
    case (ext_i)
      EXT_ZB: result_o = {24'h0, shifted_i[7:0]};
      EXT_ZH: result_o = {16'h0, shifted_i[15:0]};
      EXT_SB: result_o = {{24{shifted_i[7]}}, shifted_i[7:0]};
      EXT_SH: result_o = {{16{shifted_i[15]}}, shifted_i[15:0]};
      EXT_W:  result_o = shifted_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time onto a word-addressed
// valid/ready data bus, with store lane alignment, load extension,
// a bus-progress timeout and a one-cycle response pulse.
//
// Handshakes: the core request is taken on req_valid & req_ready (ready
// only in IDLE); the bus request is taken on mem_valid & mem_ready, and
// mem_valid with its address/data/strobes stays stable until then; load
// data is taken on mem_rvalid while waiting; resp_valid cannot be stalled.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output state_e      dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [1:0]    off_q;
  ext_e          ext_q;

  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic          mem_valid_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wstrb_q;

  logic [31:0]   st_wdata_d;
  logic [3:0]    st_wstrb_d;
  logic          legal_d;
  logic [31:0]   rd_shifted;
  logic [31:0]   rd_ext;

  // Store lane replication and byte strobes for the incoming request.
  always_comb begin
    st_wdata_d = 32'h0;
    st_wstrb_d = 4'b0000;
    case (req_funct3)
      F3_B: begin
        st_wdata_d = {4{req_wdata[7:0]}};
        st_wstrb_d = 4'b0001 << req_addr[1:0];
      end
      F3_H: begin
        st_wdata_d = {2{req_wdata[15:0]}};
        st_wstrb_d = 4'b0011 << req_addr[1:0];
      end
      F3_W: begin
        st_wdata_d = req_wdata;
        st_wstrb_d = 4'b1111;
      end
      default: begin
        st_wdata_d = 32'h0;
        st_wstrb_d = 4'b0000;
      end
    endcase
  end

  assign legal_d    = req_legal(req_we, req_funct3, req_addr[1:0]);
  assign rd_shifted = mem_rdata >> {off_q, 3'b000};

  load_ext u_load_ext (
    .shifted_i (rd_shifted),
    .ext_i     (ext_q),
    .result_o  (rd_ext)
  );

  // Sequencer FSM with its timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      off_q        <= 2'b00;
      ext_q        <= EXT_W;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            off_q       <= req_addr[1:0];
            ext_q       <= ext_code(req_funct3);
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (legal_d) begin
              state_q     <= ST_REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[31:2], 2'b00};
              mem_wdata_q <= req_we ? st_wdata_d : 32'h0;
              mem_wstrb_q <= req_we ? st_wstrb_d : 4'b0000;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          if (mem_ready || (cnt_q == TO_LAST)) begin
            // Bus request ends either way; clear its payload with it.
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            cnt_q       <= '0;
            if (!mem_ready) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (we_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT: begin
          if (mem_rvalid) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rd_ext;
          end else if (cnt_q == TO_LAST) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          req_ready_q  <= 1'b1;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign dbg_state  = state_q;

endmodule
